// File: rtl/door_pkg.sv
// Shared state codes, default timing values and direction type for the door motion sequencer.
package door_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] INIT      = 3'd0;
  localparam logic [STATE_W-1:0] CLOSED    = 3'd1;
  localparam logic [STATE_W-1:0] OPENING   = 3'd2;
  localparam logic [STATE_W-1:0] OPEN_HOLD = 3'd3;
  localparam logic [STATE_W-1:0] CLOSING   = 3'd4;
  localparam logic [STATE_W-1:0] DEADTIME  = 3'd5;
  localparam logic [STATE_W-1:0] STOPPED   = 3'd6;
  localparam logic [STATE_W-1:0] FAULT     = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT      = INIT,
    ST_CLOSED    = CLOSED,
    ST_OPENING   = OPENING,
    ST_OPEN_HOLD = OPEN_HOLD,
    ST_CLOSING   = CLOSING,
    ST_DEADTIME  = DEADTIME,
    ST_STOPPED   = STOPPED,
    ST_FAULT     = FAULT
  } door_state_t;

  localparam int unsigned DEF_CNT_W           = 16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES     = 1000;
  localparam int unsigned DEF_MOVE_TIMEOUT    = 4000;
  localparam int unsigned DEF_DEADTIME_CYCLES = 8;

  typedef enum logic {
    DIR_OPEN  = 1'b0,
    DIR_CLOSE = 1'b1
  } dir_t;

endpackage

// File: rtl/door_input_debounce.sv
// Per-bit 2-FF synchroniser followed by a consecutive-cycle debounce counter.
module door_input_debounce
  import door_pkg::*;
#(
  parameter int unsigned W               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);

  localparam int unsigned DB_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]        sync1;
  logic [W-1:0]        sync2;
  logic [DB_CNT_W-1:0] cnt [W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < int'(W); i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // A bit flips only after its synchronised value disagrees for DEBOUNCE_CYCLES cycles in a row.
      for (int i = 0; i < int'(W); i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/door_motion_sequencer.sv
// Door motor sequencer: conditioned inputs drive an open/hold/close FSM with timeouts and fault latch.
// Optional DOOR_REVERSE_EN: presence during CLOSING reverses through DEADTIME into OPENING.
module door_motion_sequencer
  import door_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned MOVE_TIMEOUT    = DEF_MOVE_TIMEOUT,
  parameter int unsigned DEADTIME_CYCLES = DEF_DEADTIME_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sen,
  input  logic               se,
  input  logic               la,
  input  logic               lc,
  input  logic               fault_clr,
  output logic               motor_open,
  output logic               motor_close,
  output logic [STATE_W-1:0] state,
  output logic               fault
);

  localparam int unsigned IN_W = 4;
  localparam logic [CNT_W-1:0] TMR_MAX   = '1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DEBOUNCE_CYCLES + 2);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  logic [IN_W-1:0] in_db;
  logic            sen_db, se_db, la_db, lc_db;
  logic [1:0]      clr_sync;
  logic            clr_s;

  door_state_t      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_up;
  dir_t             dir_q, dir_d;

  door_input_debounce #(
    .W               (IN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({sen, se, la, lc}),
    .db    (in_db)
  );

  assign {sen_db, se_db, la_db, lc_db} = in_db;
  assign clr_s = clr_sync[1];
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      timer_q     <= '0;
      dir_q       <= DIR_OPEN;
      clr_sync    <= '0;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      dir_q       <= dir_d;
      clr_sync    <= {clr_sync[0], fault_clr};
      motor_open  <= (state_d == ST_OPENING);
      motor_close <= (state_d == ST_CLOSING);
      fault       <= (state_d == ST_FAULT);
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    timer_up = (timer_q == TMR_MAX) ? timer_q : timer_q + CNT_W'(1);
    timer_d  = timer_up;

    if (state_q != ST_INIT && la_db && lc_db) begin
      state_d = ST_FAULT;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (timer_q == INIT_LAST) begin
            if (lc_db)      state_d = ST_CLOSED;
            else if (la_db) state_d = ST_OPEN_HOLD;
            else            state_d = ST_CLOSING;
          end
        end
        ST_CLOSED: begin
          // Motion is never started while the emergency stop is held.
          if (!se_db) begin
            if (sen_db)      state_d = ST_OPENING;
            else if (!lc_db) state_d = ST_CLOSING;
          end
        end
        ST_OPENING: begin
          if (se_db)                       state_d = ST_STOPPED;
          else if (la_db)                  state_d = ST_OPEN_HOLD;
          else if (timer_q == MOVE_LAST)   state_d = ST_FAULT;
        end
        ST_OPEN_HOLD: begin
          if (sen_db || se_db)             timer_d = HOLD_LOAD;
          else if (timer_q <= CNT_W'(1))   state_d = ST_CLOSING;
          else                             timer_d = timer_q - CNT_W'(1);
        end
        ST_CLOSING: begin
          if (se_db) begin
            state_d = ST_STOPPED;
          end else if (lc_db) begin
            state_d = ST_CLOSED;
          end
`ifdef DOOR_REVERSE_EN
          else if (sen_db) begin
            state_d = ST_DEADTIME;
            dir_d   = DIR_OPEN;
          end
`endif
          else if (timer_q == MOVE_LAST) begin
            state_d = ST_FAULT;
          end
        end
        ST_DEADTIME: begin
          if (se_db)                     state_d = ST_STOPPED;
          else if (timer_q == DEAD_LAST) state_d = (dir_q == DIR_OPEN) ? ST_OPENING : ST_CLOSING;
        end
        ST_STOPPED: begin
          if (!se_db) begin
            if (lc_db) begin
              state_d = ST_CLOSED;
            end else begin
              state_d = ST_DEADTIME;
              dir_d   = DIR_OPEN;
            end
          end
        end
        ST_FAULT: begin
          if (clr_s && !la_db && !lc_db && !se_db) state_d = ST_INIT;
        end
        default: state_d = ST_FAULT;
      endcase
    end

    // Every state entry restarts the shared timer.
    if (state_d != state_q) timer_d = (state_d == ST_OPEN_HOLD) ? HOLD_LOAD : '0;
  end

endmodule

// File: tb/tb_door_motion_sequencer.sv
// Randomized self-checking bench for door_motion_sequencer; timing expectations come from latency arithmetic.
module tb_door_motion_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int TOUT = 50;
  localparam int DT   = 3;
  // raw edge -> synchroniser (2) -> debounce (DEB) -> state register (1)
  localparam int LAT  = 2 + DEB + 1;

  localparam int S_INIT = 0, S_CLOSED = 1, S_OPENING = 2, S_OPEN_HOLD = 3;
  localparam int S_CLOSING = 4, S_DEADTIME = 5, S_STOPPED = 6, S_FAULT = 7;
  localparam int M_OFF = 0, M_CLOSE = 1, M_OPEN = 2;

  logic       clk = 1'b0;
  logic       rst_n, sen, se, la, lc, fault_clr;
  logic       motor_open, motor_close, fault;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  door_motion_sequencer #(
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .MOVE_TIMEOUT    (TOUT),
    .DEADTIME_CYCLES (DT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sen         (sen),
    .se          (se),
    .la          (la),
    .lc          (lc),
    .fault_clr   (fault_clr),
    .motor_open  (motor_open),
    .motor_close (motor_close),
    .state       (state),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int motors();
    return int'({motor_open, motor_close});
  endfunction

  task automatic chk_st(input string tag, input int exp);
    check(tag, int'(state), exp);
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      tick(1);
      n++;
    end
    chk_st(tag, target);
  endtask

  // CLOSED -> OPENING via a presence pulse of random length; returns with sen low.
  task automatic open_from_closed();
    int p = 10 + int'($urandom_range(4));
    sen = 1'b1;
    tick(LAT - 1); chk_st("open_latency_pre", S_CLOSED);
    tick(1);       chk_st("open_latency", S_OPENING);
    check("opening_motors", motors(), M_OPEN);
    lc = 1'b0;
    tick(p - LAT);
    sen = 1'b0;
  endtask

  // OPENING -> OPEN_HOLD on the open limit, then hold expiry into CLOSING.
  task automatic run_to_closing();
    tick(int'($urandom_range(5)));
    la = 1'b1;
    tick(LAT - 1); chk_st("la_pre", S_OPENING);
    tick(1);       chk_st("la_open_hold", S_OPEN_HOLD);
    check("hold_motors", motors(), M_OFF);
    tick(HOLD - 1); chk_st("hold_pre", S_OPEN_HOLD);
    tick(1);        chk_st("hold_expire", S_CLOSING);
    check("closing_motors", motors(), M_CLOSE);
    la = 1'b0;
  endtask

  task automatic close_from_closing();
    tick(1 + int'($urandom_range(4)));
    lc = 1'b1;
    tick(LAT - 1); chk_st("lc_pre", S_CLOSING);
    tick(1);       chk_st("lc_closed", S_CLOSED);
    check("closed_motors", motors(), M_OFF);
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sen = 1'b0; se = 1'b0; la = 1'b0; lc = 1'b1; fault_clr = 1'b0;
    tick(2);
    chk_st("reset_state", S_INIT);
    check("reset_motors", motors(), M_OFF);
    check("reset_fault", int'(fault), 0);
    rst_n = 1'b1;
    tick(DEB + 2); chk_st("init_wait", S_INIT);
    tick(1);       chk_st("init_to_closed", S_CLOSED);
    check("init_motors", motors(), M_OFF);
    tick(int'($urandom_range(5)));
    chk_st("closed_idle", S_CLOSED);

    // Full open / hold / close cycle
    open_from_closed();
    run_to_closing();
    close_from_closing();

    // Presence during CLOSING
    open_from_closed();
    run_to_closing();
    sen = 1'b1;
`ifdef DOOR_REVERSE_EN
    tick(LAT - 1); chk_st("rev_pre", S_CLOSING);
    for (int i = 0; i < DT; i++) begin
      tick(1);
      chk_st("rev_deadtime", S_DEADTIME);
      check("rev_dead_motors", motors(), M_OFF);
    end
    tick(1); chk_st("rev_reopen", S_OPENING);
    check("rev_open_motors", motors(), M_OPEN);
    sen = 1'b0;
    la  = 1'b1;
    wait_state("rev_hold", S_OPEN_HOLD, 20);
    wait_state("rev_close", S_CLOSING, 40);
    la = 1'b0;
    lc = 1'b1;
    wait_state("rev_closed", S_CLOSED, 20);
`else
    tick(4); sen = 1'b0;
    tick(1); lc = 1'b1;
    tick(2); chk_st("norev_closing", S_CLOSING);
    check("norev_motors", motors(), M_CLOSE);
    tick(3); chk_st("norev_closing2", S_CLOSING);
    tick(2); chk_st("norev_closed", S_CLOSED);
`endif

    // Emergency stop in OPENING, release reopens through DEADTIME
    open_from_closed();
    tick(int'($urandom_range(3)));
    se = 1'b1;
    tick(LAT - 1); chk_st("estop_pre", S_OPENING);
    tick(1);       chk_st("estop", S_STOPPED);
    check("estop_motors", motors(), M_OFF);
    tick(2 + int'($urandom_range(4))); chk_st("estop_held", S_STOPPED);
    se = 1'b0;
    tick(LAT - 1); chk_st("release_pre", S_STOPPED);
    tick(1);       chk_st("release_dead", S_DEADTIME);
    check("release_dead_motors", motors(), M_OFF);
    tick(DT - 1);  chk_st("release_dead_end", S_DEADTIME);
    tick(1);       chk_st("release_reopen", S_OPENING);

    // Motion timeout with the open limit never reached
    tick(TOUT - 1); chk_st("timeout_pre", S_OPENING);
    tick(1);        chk_st("timeout", S_FAULT);
    check("timeout_fault", int'(fault), 1);
    check("timeout_motors", motors(), M_OFF);
    tick(5); chk_st("fault_latched", S_FAULT);

    // Clear with inputs idle: INIT, then homing close
    pulse_clr();
    tick(1); chk_st("clr_sync_pre", S_FAULT);
    tick(1); chk_st("clr_to_init", S_INIT);
    check("clr_fault_low", int'(fault), 0);
    tick(DEB + 2); chk_st("home_pre", S_INIT);
    tick(1);       chk_st("home_closing", S_CLOSING);
    close_from_closing();

    // Limit conflict from OPEN_HOLD, blocked clear, then valid clear
    open_from_closed();
    tick(int'($urandom_range(3)));
    la = 1'b1;
    tick(LAT); chk_st("conf_hold", S_OPEN_HOLD);
    lc = 1'b1;
    tick(LAT - 1); chk_st("conf_pre", S_OPEN_HOLD);
    tick(1);       chk_st("conflict", S_FAULT);
    check("conflict_fault", int'(fault), 1);
    pulse_clr();
    tick(4); chk_st("clr_ignored", S_FAULT);
    la = 1'b0; lc = 1'b0;
    tick(LAT); chk_st("fault_hold_recover", S_FAULT);
    pulse_clr();
    tick(2); chk_st("clr_init", S_INIT);
    tick(DEB + 3); chk_st("home2", S_CLOSING);
    check("home2_motors", motors(), M_CLOSE);

    // Asynchronous reset mid-CLOSING
    #3 rst_n = 1'b0;
    #1 check("async_rst_motor", int'(motor_close), 0);
    chk_st("async_rst_state", S_INIT);
    rst_n = 1'b1;
    tick(1);

    // Random input activity: output/state relationships must always hold
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) sen = ~sen;
      if ($urandom_range(15) == 0) se = ~se;
      if ($urandom_range(9) == 0) la = ~la;
      if ($urandom_range(9) == 0) lc = ~lc;
      fault_clr = ($urandom_range(15) == 0);
      tick(1);
      check("invariant", int'({motor_open & motor_close,
                               motor_open != (state == 3'd2),
                               motor_close != (state == 3'd4),
                               fault != (state == 3'd7)}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
